// File: rtl/i_ddr_deser_if.sv
// Parallel-side bundle of the DDR input deserializer: serial data, enable and
// slip request in; deserialized word and its strobe out.
interface i_ddr_deser_if #(
  parameter int WIDTH = 4
);
  logic             D;
  logic             E;
  logic             BITSLIP;
  logic [WIDTH-1:0] Q;
  logic             DV;

  modport master (output D, output E, output BITSLIP, input  Q, input  DV);
  modport slave  (input  D, input  E, input  BITSLIP, output Q, output DV);
endinterface

// File: rtl/i_ddr_deser.sv
// DDR input deserializer. D is sampled on both edges of C, pairs of bits are
// pushed into a WIDTH+1 bit shift register on rising C, and a WIDTH-bit window
// is published every WIDTH/2 shifting edges. The spare SR bit lets BITSLIP
// move the window one bit older (PHASE=1) without reshuffling stored data.
// WIDTH must be even, 4..16.
module i_ddr_deser #(
  parameter int WIDTH = 4
) (
  input  logic          C,
  input  logic          R,
  i_ddr_deser_if.slave  bus
);

  localparam int HALF = WIDTH / 2;
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HALF - 1);

  logic             r_pos;
  logic             r_neg;
  logic             r_prime;
  logic [WIDTH:0]   r_sr;
  logic [CW-1:0]    r_cnt;
  logic             r_phase;
  logic [WIDTH-1:0] r_q;
  logic             r_dv;

  logic [WIDTH:0]   w_sr_nxt;
  logic             w_phase_nxt;
  logic             w_adv;
  logic             w_wrap;
  logic [WIDTH-1:0] w_win;

  // Next-state of the shifting datapath; only consumed on shifting edges.
  // The pair captured last cycle enters at the top, POS being the older bit.
  assign w_sr_nxt    = {r_neg, r_pos, r_sr[WIDTH:2]};
  assign w_phase_nxt = r_phase ^ bus.BITSLIP;
  // A slip out of PHASE=0 costs one edge: the counter holds so the word
  // period stretches by two bits while the window steps back by one.
  assign w_adv       = !(bus.BITSLIP && !r_phase);
  assign w_wrap      = w_adv && (r_cnt == CNT_LAST);
  assign w_win       = w_phase_nxt ? w_sr_nxt[WIDTH-1:0] : w_sr_nxt[WIDTH:1];

  // Falling-edge capture: the later bit of each pair.
  always_ff @(negedge C or negedge R) begin
    if (!R)         r_neg <= 1'b0;
    else if (bus.E) r_neg <= bus.D;
  end

  // Rising-edge capture, shift, word count, slip and word publish.
  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      r_pos   <= 1'b0;
      r_prime <= 1'b0;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_phase <= 1'b0;
      r_q     <= '0;
      r_dv    <= 1'b0;
    end else begin
      r_dv <= 1'b0;
      if (bus.E) begin
        r_pos   <= bus.D;
        r_prime <= 1'b1;
        // The first enabled edge only primes POS; NEG is not valid yet.
        if (r_prime) begin
          r_sr    <= w_sr_nxt;
          r_phase <= w_phase_nxt;
          if (w_adv) r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
          if (w_wrap) begin
            r_q  <= w_win;
            r_dv <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.Q  = r_q;
  assign bus.DV = r_dv;

endmodule
